// File: rtl/riscv_bus_pkg.sv
// rtl/riscv_bus_pkg.sv - shared types for the iBus/dBus memory arbiter
package riscv_bus_pkg;

    typedef enum logic {SRC_I, SRC_D} bus_src_t;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} bus_size_t;

    typedef enum logic [1:0] {G_IDLE, G_I, G_D} grant_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - bundle of core-side and memory-side bus signals
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iBus_cmd_valid;
    logic              iBus_cmd_ready;
    logic [ADDR_W-1:0] iBus_cmd_payload_pc;
    logic              iBus_rsp_ready;
    logic              iBus_rsp_err;
    logic [DATA_W-1:0] iBus_rsp_inst;

    logic              dBus_cmd_valid;
    logic              dBus_cmd_ready;
    logic              dBus_cmd_payload_wr;
    logic [ADDR_W-1:0] dBus_cmd_payload_address;
    logic [DATA_W-1:0] dBus_cmd_payload_data;
    logic [1:0]        dBus_cmd_payload_size;
    logic              dBus_rsp_ready;
    logic              dBus_rsp_err;
    logic [DATA_W-1:0] dBus_rsp_data;

    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_wr;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [DATA_W-1:0] mem_cmd_wdata;
    logic [1:0]        mem_cmd_size;
    logic              mem_rsp_valid;
    logic              mem_rsp_err;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              stray_rsp;

    // Arbiter side
    modport master (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        input  dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_err, dBus_rsp_data,
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_size,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_err, mem_rsp_data,
        output stray_rsp
    );

    // Core and memory side
    modport slave (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_inst,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        output dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_err, dBus_rsp_data,
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_size,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_err, mem_rsp_data,
        input  stray_rsp
    );

endinterface

// File: rtl/mem_bus_arbiter_tag_fifo.sv
// rtl/mem_bus_arbiter_tag_fifo.sv - in-order FIFO of 1-bit source tags
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstf,
    input  logic push,
    input  logic push_src,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] tags;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = tags[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            tags[wr_ptr] <= push_src;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin iBus/dBus arbiter onto one memory port
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rstf,
    mem_bus_arbiter_if.master bus
);
    grant_state_t state;
    bus_src_t     last_src;
    bus_src_t     sel_src;
    bus_src_t     head_src;
    logic         cmd_valid;
    logic         accept;
    logic         rsp_fire;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_head;
    logic         stray_q;

    // Full comes from the registered count, so a same-cycle pop never frees a slot
    always_comb begin
        sel_src   = SRC_I;
        cmd_valid = 1'b0;
        case (state)
            G_I: begin
                sel_src   = SRC_I;
                cmd_valid = bus.iBus_cmd_valid;
            end
            G_D: begin
                sel_src   = SRC_D;
                cmd_valid = bus.dBus_cmd_valid;
            end
            default: begin
                if (!fifo_full) begin
                    if (bus.iBus_cmd_valid && bus.dBus_cmd_valid) begin
                        sel_src = (last_src == SRC_I) ? SRC_D : SRC_I;
                    end else if (bus.dBus_cmd_valid) begin
                        sel_src = SRC_D;
                    end
                    cmd_valid = bus.iBus_cmd_valid | bus.dBus_cmd_valid;
                end
            end
        endcase
    end

    assign bus.mem_cmd_valid  = cmd_valid & rstf;
    assign accept             = bus.mem_cmd_valid & bus.mem_cmd_ready;
    assign bus.iBus_cmd_ready = accept & (sel_src == SRC_I);
    assign bus.dBus_cmd_ready = accept & (sel_src == SRC_D);

    always_comb begin
        bus.mem_cmd_wr    = 1'b0;
        bus.mem_cmd_addr  = bus.iBus_cmd_payload_pc;
        bus.mem_cmd_wdata = '0;
        bus.mem_cmd_size  = SIZE_W;
        if (sel_src == SRC_D) begin
            bus.mem_cmd_wr    = bus.dBus_cmd_payload_wr;
            bus.mem_cmd_addr  = bus.dBus_cmd_payload_address;
            bus.mem_cmd_wdata = bus.dBus_cmd_payload_data;
            bus.mem_cmd_size  = bus.dBus_cmd_payload_size;
        end
    end

    // A locked requester that drops valid falls back to idle without a tag
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state    <= G_IDLE;
            last_src <= SRC_D;
        end else if (accept) begin
            state    <= G_IDLE;
            last_src <= sel_src;
        end else if (cmd_valid) begin
            state <= (sel_src == SRC_I) ? G_I : G_D;
        end else begin
            state <= G_IDLE;
        end
    end

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rstf     (rstf),
        .push     (accept),
        .push_src (sel_src),
        .pop      (rsp_fire),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign head_src           = bus_src_t'(fifo_head);
    assign rsp_fire           = bus.mem_rsp_valid & ~fifo_empty & rstf;
    assign bus.iBus_rsp_ready = rsp_fire & (head_src == SRC_I);
    assign bus.dBus_rsp_ready = rsp_fire & (head_src == SRC_D);
    assign bus.iBus_rsp_err   = bus.iBus_rsp_ready & bus.mem_rsp_err;
    assign bus.dBus_rsp_err   = bus.dBus_rsp_ready & bus.mem_rsp_err;
    assign bus.iBus_rsp_inst  = rstf ? bus.mem_rsp_data : '0;
    assign bus.dBus_rsp_data  = rstf ? bus.mem_rsp_data : '0;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            stray_q <= 1'b0;
        end else if (bus.mem_rsp_valid && fifo_empty) begin
            stray_q <= 1'b1;
        end
    end

    assign bus.stray_rsp = stray_q;

    a_lock_i_held: assert property (@(posedge clk) disable iff (!rstf)
        (state == G_I) |-> bus.iBus_cmd_valid);
    a_lock_d_held: assert property (@(posedge clk) disable iff (!rstf)
        (state == G_D) |-> bus.dBus_cmd_valid);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rstf = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_bus_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk  (clk),
        .rstf (rstf),
        .bus  (bif.master)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bif.iBus_cmd_valid           = 1'b0;
        bif.iBus_cmd_payload_pc      = '0;
        bif.dBus_cmd_valid           = 1'b0;
        bif.dBus_cmd_payload_wr      = 1'b0;
        bif.dBus_cmd_payload_address = '0;
        bif.dBus_cmd_payload_data    = '0;
        bif.dBus_cmd_payload_size    = 2'd0;
        bif.mem_cmd_ready            = 1'b0;
        bif.mem_rsp_valid            = 1'b0;
        bif.mem_rsp_err              = 1'b0;
        bif.mem_rsp_data             = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstf = 1'b0;
        clear_inputs();
        @(negedge clk);
        rstf = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bif.iBus_cmd_valid = 1'b1;
        bif.dBus_cmd_valid = 1'b1;
        bif.mem_cmd_ready  = 1'b1;
        bif.mem_rsp_valid  = 1'b1;
        bif.mem_rsp_data   = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        n_cmp++; if (bif.mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_cmd_valid got %b want 0", bif.mem_cmd_valid); end
        n_cmp++; if (bif.iBus_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_i_cmd_ready got %b want 0", bif.iBus_cmd_ready); end
        n_cmp++; if (bif.dBus_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_cmd_ready got %b want 0", bif.dBus_cmd_ready); end
        n_cmp++; if ({bif.iBus_rsp_ready, bif.dBus_rsp_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_ready got %b want 00", {bif.iBus_rsp_ready, bif.dBus_rsp_ready}); end
        n_cmp++; if (bif.iBus_rsp_inst !== 32'h0) begin n_bad++; $display("FAIL rst_i_rsp_inst got %h want 0", bif.iBus_rsp_inst); end
        n_cmp++; if (bif.stray_rsp !== 1'b0) begin n_bad++; $display("FAIL rst_stray got %b want 0", bif.stray_rsp); end
        clear_inputs();
        rstf = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bif.mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_mem_cmd_valid got %b want 0", bif.mem_cmd_valid); end
        n_cmp++; if (bif.stray_rsp !== 1'b0) begin n_bad++; $display("FAIL post_rst_stray got %b want 0", bif.stray_rsp); end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        bif.iBus_cmd_valid      = 1'b1;
        bif.iBus_cmd_payload_pc = 32'h100;
        bif.mem_cmd_ready       = 1'b1;
        #1;
        n_cmp++; if (bif.iBus_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_cmd_ready got %b want 1", bif.iBus_cmd_ready); end
        n_cmp++; if (bif.dBus_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_d_cmd_ready got %b want 0", bif.dBus_cmd_ready); end
        n_cmp++; if (bif.mem_cmd_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_addr got %h want 00000100", bif.mem_cmd_addr); end
        n_cmp++; if ({bif.mem_cmd_wr, bif.mem_cmd_size} !== 3'b010) begin n_bad++; $display("FAIL fetch_wr_size got %b want 010", {bif.mem_cmd_wr, bif.mem_cmd_size}); end
        n_cmp++; if (bif.mem_cmd_wdata !== 32'h0) begin n_bad++; $display("FAIL fetch_wdata got %h want 0", bif.mem_cmd_wdata); end
        @(negedge clk);
        bif.iBus_cmd_valid = 1'b0;
        bif.mem_cmd_ready  = 1'b0;
        bif.mem_rsp_valid  = 1'b1;
        bif.mem_rsp_data   = 32'h0000_0013;
        #1;
        n_cmp++; if (bif.iBus_rsp_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_rsp_ready got %b want 1", bif.iBus_rsp_ready); end
        n_cmp++; if (bif.iBus_rsp_inst !== 32'h13) begin n_bad++; $display("FAIL fetch_rsp_inst got %h want 00000013", bif.iBus_rsp_inst); end
        n_cmp++; if (bif.dBus_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_d_rsp_ready got %b want 0", bif.dBus_rsp_ready); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (bif.iBus_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_rsp_pulse got %b want 0", bif.iBus_rsp_ready); end
    endtask

    task automatic test_round_robin();
        logic exp_i;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bif.iBus_cmd_valid           = (k < 4);
            bif.iBus_cmd_payload_pc      = 32'h400 + 32'(k);
            bif.dBus_cmd_valid           = (k < 4);
            bif.dBus_cmd_payload_address = 32'h800 + 32'(k);
            bif.dBus_cmd_payload_size    = 2'd2;
            bif.mem_cmd_ready            = 1'b1;
            bif.mem_rsp_valid            = (k >= 1);
            bif.mem_rsp_data             = 32'hA0 + 32'(k);
            #1;
            if (k < 4) begin
                exp_i = ((k % 2) == 0);
                n_cmp++; if ({bif.iBus_cmd_ready, bif.dBus_cmd_ready} !== {exp_i, ~exp_i}) begin n_bad++; $display("FAIL rr_grant k=%0d got %b want %b", k, {bif.iBus_cmd_ready, bif.dBus_cmd_ready}, {exp_i, ~exp_i}); end
            end
            if (k >= 1) begin
                exp_i = (((k - 1) % 2) == 0);
                n_cmp++; if ({bif.iBus_rsp_ready, bif.dBus_rsp_ready} !== {exp_i, ~exp_i}) begin n_bad++; $display("FAIL rr_rsp k=%0d got %b want %b", k, {bif.iBus_rsp_ready, bif.dBus_rsp_ready}, {exp_i, ~exp_i}); end
                n_cmp++; if ((exp_i ? bif.iBus_rsp_inst : bif.dBus_rsp_data) !== 32'hA0 + 32'(k)) begin n_bad++; $display("FAIL rr_rsp_data k=%0d got %h want %h", k, (exp_i ? bif.iBus_rsp_inst : bif.dBus_rsp_data), 32'hA0 + 32'(k)); end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_hold_grant();
        // One fetch first so that dBus wins the following tie
        @(negedge clk);
        bif.iBus_cmd_valid      = 1'b1;
        bif.iBus_cmd_payload_pc = 32'h200;
        bif.mem_cmd_ready       = 1'b1;
        @(negedge clk);
        clear_inputs();
        bif.mem_rsp_valid = 1'b1;
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bif.iBus_cmd_valid           = 1'b1;
            bif.iBus_cmd_payload_pc      = 32'h300;
            bif.dBus_cmd_valid           = 1'b1;
            bif.dBus_cmd_payload_wr      = 1'b1;
            bif.dBus_cmd_payload_address = 32'h2000;
            bif.dBus_cmd_payload_data    = 32'hDEAD_BEEF;
            bif.dBus_cmd_payload_size    = 2'd2;
            bif.mem_cmd_ready            = (c == 3);
            #1;
            n_cmp++; if ({bif.mem_cmd_valid, bif.mem_cmd_wr, bif.mem_cmd_addr, bif.mem_cmd_wdata} !== {2'b11, 32'h2000, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL hold_cmd c=%0d got %b/%b/%h/%h want 1/1/00002000/deadbeef", c, bif.mem_cmd_valid, bif.mem_cmd_wr, bif.mem_cmd_addr, bif.mem_cmd_wdata); end
            n_cmp++; if ({bif.dBus_cmd_ready, bif.iBus_cmd_ready} !== {(c == 3), 1'b0}) begin n_bad++; $display("FAIL hold_ready c=%0d got %b want %b", c, {bif.dBus_cmd_ready, bif.iBus_cmd_ready}, {(c == 3), 1'b0}); end
        end
        @(negedge clk);
        bif.dBus_cmd_valid = 1'b0;
        #1;
        n_cmp++; if (bif.iBus_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL hold_next_i got %b want 1", bif.iBus_cmd_ready); end
        n_cmp++; if ({bif.mem_cmd_wr, bif.mem_cmd_addr, bif.mem_cmd_wdata} !== {1'b0, 32'h300, 32'h0}) begin n_bad++; $display("FAIL hold_next_cmd got %b/%h/%h want 0/00000300/00000000", bif.mem_cmd_wr, bif.mem_cmd_addr, bif.mem_cmd_wdata); end
        @(negedge clk);
        clear_inputs();
        bif.mem_rsp_valid = 1'b1;
        bif.mem_rsp_err   = 1'b1;
        bif.mem_rsp_data  = 32'h5555_0001;
        #1;
        n_cmp++; if ({bif.dBus_rsp_ready, bif.dBus_rsp_err, bif.iBus_rsp_ready, bif.iBus_rsp_err} !== 4'b1100) begin n_bad++; $display("FAIL hold_rsp_d got %b want 1100", {bif.dBus_rsp_ready, bif.dBus_rsp_err, bif.iBus_rsp_ready, bif.iBus_rsp_err}); end
        @(negedge clk);
        bif.mem_rsp_err  = 1'b0;
        bif.mem_rsp_data = 32'h5555_0002;
        #1;
        n_cmp++; if ({bif.iBus_rsp_ready, bif.dBus_rsp_ready, bif.iBus_rsp_err} !== 3'b100) begin n_bad++; $display("FAIL hold_rsp_i got %b want 100", {bif.iBus_rsp_ready, bif.dBus_rsp_ready, bif.iBus_rsp_err}); end
        n_cmp++; if (bif.iBus_rsp_inst !== 32'h5555_0002) begin n_bad++; $display("FAIL hold_rsp_inst got %h want 55550002", bif.iBus_rsp_inst); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (bif.stray_rsp !== 1'b0) begin n_bad++; $display("FAIL hold_no_stray got %b want 0", bif.stray_rsp); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bif.iBus_cmd_valid      = 1'b1;
            bif.iBus_cmd_payload_pc = 32'h1000 + 32'(c * 4);
            bif.mem_cmd_ready       = 1'b1;
            bif.mem_rsp_valid       = (c == 5);
            #1;
            n_cmp++; if ({bif.mem_cmd_valid, bif.iBus_cmd_ready} !== {2{(c < 4) || (c == 6)}}) begin n_bad++; $display("FAIL full c=%0d got %b want %b", c, {bif.mem_cmd_valid, bif.iBus_cmd_ready}, {2{(c < 4) || (c == 6)}}); end
            if (c == 5) begin
                n_cmp++; if (bif.iBus_rsp_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_rsp got %b want 1", bif.iBus_rsp_ready); end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_stray();
        do_reset();
        @(negedge clk);
        bif.mem_rsp_valid = 1'b1;
        #1;
        n_cmp++; if ({bif.iBus_rsp_ready, bif.dBus_rsp_ready, bif.stray_rsp} !== 3'b000) begin n_bad++; $display("FAIL stray_cycle got %b want 000", {bif.iBus_rsp_ready, bif.dBus_rsp_ready, bif.stray_rsp}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bif.mem_rsp_valid = 1'b0;
            #1;
            n_cmp++; if (bif.stray_rsp !== 1'b1) begin n_bad++; $display("FAIL stray_sticky c=%0d got %b want 1", c, bif.stray_rsp); end
        end
        rstf = 1'b0;
        #1;
        n_cmp++; if (bif.stray_rsp !== 1'b0) begin n_bad++; $display("FAIL stray_clear got %b want 0", bif.stray_rsp); end
        @(negedge clk);
        rstf = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        @(negedge clk);
        bif.iBus_cmd_valid = 1'b1;
        bif.dBus_cmd_valid = 1'b1;
        bif.mem_cmd_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bif.dBus_cmd_valid = 1'b0;
        bif.mem_cmd_ready  = 1'b0;
        #1;
        n_cmp++; if (bif.mem_cmd_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %b want 1", bif.mem_cmd_valid); end
        #2;
        rstf = 1'b0;
        bif.mem_cmd_ready = 1'b1;
        #1;
        n_cmp++; if ({bif.mem_cmd_valid, bif.iBus_cmd_ready, bif.dBus_cmd_ready} !== 3'b000) begin n_bad++; $display("FAIL mid_drop got %b want 000", {bif.mem_cmd_valid, bif.iBus_cmd_ready, bif.dBus_cmd_ready}); end
        @(negedge clk);
        clear_inputs();
        rstf = 1'b1;
        bif.mem_rsp_valid = 1'b1;
        #1;
        n_cmp++; if ({bif.iBus_rsp_ready, bif.dBus_rsp_ready} !== 2'b00) begin n_bad++; $display("FAIL mid_late_rsp got %b want 00", {bif.iBus_rsp_ready, bif.dBus_rsp_ready}); end
        @(negedge clk);
        bif.mem_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bif.stray_rsp !== 1'b1) begin n_bad++; $display("FAIL mid_stray got %b want 1", bif.stray_rsp); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_hold_grant();
        test_fifo_full();
        test_stray();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
